mult8_seq_ctrl: RTL



---
 rtl/mult8_seq_pkg.sv | 29 ++
 rtl/mul4x4_core.sv | 42 ++++
 rtl/mult8_seq_ctrl.sv | 106 ++++++++++
 3 files changed

// File: rtl/mult8_seq_pkg.sv
// rtl/mult8_seq_pkg.sv - shared types and constants for the sequential 8x8 multiplier
package mult8_seq_pkg;

    localparam int DIGIT_W   = 4;
    localparam int OPERAND_W = 2 * DIGIT_W;
    localparam int RESULT_W  = 2 * OPERAND_W;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        S0   = 3'd1,
        S1   = 3'd2,
        S2   = 3'd3,
        S3   = 3'd4,
        DONE = 3'd5
    } state_t;

    // Partial-product weight for steps lo*lo, hi*lo, lo*hi, hi*hi
    localparam int unsigned STEP_SHIFT [4] = '{0, 4, 4, 8};

    function automatic logic [1:0] step_idx(input state_t s);
        case (s)
            S1:      return 2'd1;
            S2:      return 2'd2;
            S3:      return 2'd3;
            default: return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/mul4x4_core.sv
// rtl/mul4x4_core.sv - combinational 4x4->8 unsigned array multiplier of full-adder rows
module mul4x4_core
    import mult8_seq_pkg::*;
(
    input  logic [DIGIT_W-1:0]   a_i,
    input  logic [DIGIT_W-1:0]   b_i,
    output logic [2*DIGIT_W-1:0] p_o
);

    logic [3:0] pp      [4];
    logic [3:0] row_acc [4];
    logic [3:0] s       [1:3];
    logic [4:0] c       [1:3];

    genvar i, j;
    generate
        for (i = 0; i < 4; i++) begin : g_pp
            for (j = 0; j < 4; j++) begin : g_bit
                assign pp[i][j] = a_i[j] & b_i[i];
            end
        end

        assign p_o[0]     = pp[0][0];
        assign row_acc[0] = {1'b0, pp[0][3:1]};

        // Each row ripples the shifted running sum with the next partial product
        for (i = 1; i < 4; i++) begin : g_row
            assign c[i][0] = 1'b0;
            for (j = 0; j < 4; j++) begin : g_fa
                assign s[i][j]   = row_acc[i-1][j] ^ pp[i][j] ^ c[i][j];
                assign c[i][j+1] = (row_acc[i-1][j] & pp[i][j])
                                 | (row_acc[i-1][j] & c[i][j])
                                 | (pp[i][j] & c[i][j]);
            end
            assign p_o[i]     = s[i][0];
            assign row_acc[i] = {c[i][4], s[i][3:1]};
        end
    endgenerate

    assign p_o[7:4] = row_acc[3];

endmodule

// File: rtl/mult8_seq_ctrl.sv
// rtl/mult8_seq_ctrl.sv - 8x8 multiply sequenced over one shared 4x4 core
// Optional EARLY_ZERO_EN: zero operand skips straight to DONE.
module mult8_seq_ctrl
    import mult8_seq_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [OPERAND_W-1:0] in_a,
    input  logic [OPERAND_W-1:0] in_b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [RESULT_W-1:0]  out_p,
    output logic                 busy
);

    state_t                state_q, state_d;
    logic [RESULT_W-1:0]   acc_q, acc_d;
    logic [OPERAND_W-1:0]  a_q, a_d, b_q, b_d;
    logic                  a_hi_q, a_hi_d, b_hi_q, b_hi_d, core_en_q, core_en_d;
    logic [DIGIT_W-1:0]    core_a, core_b;
    logic [2*DIGIT_W-1:0]  core_p;
    logic                  accept, early_zero;

    assign accept = in_valid && (state_q == IDLE);

`ifdef EARLY_ZERO_EN
    assign early_zero = (in_a == '0) || (in_b == '0);
`else
    assign early_zero = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            acc_q     <= '0;
            a_q       <= '0;
            b_q       <= '0;
            a_hi_q    <= 1'b0;
            b_hi_q    <= 1'b0;
            core_en_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            a_q       <= a_d;
            b_q       <= b_d;
            a_hi_q    <= a_hi_d;
            b_hi_q    <= b_hi_d;
            core_en_q <= core_en_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = early_zero ? DONE : S0;
            S0:      state_d = S1;
            S1:      state_d = S2;
            S2:      state_d = S3;
            S3:      state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Digit selects are registered from the upcoming state so they line up with it
    always_comb begin
        a_hi_d    = (state_d == S1) || (state_d == S3);
        b_hi_d    = (state_d == S2) || (state_d == S3);
        core_en_d = (state_d == S0) || (state_d == S1) || (state_d == S2) || (state_d == S3);
    end

    assign core_a = core_en_q ? (a_hi_q ? a_q[7:4] : a_q[3:0]) : '0;
    assign core_b = core_en_q ? (b_hi_q ? b_q[7:4] : b_q[3:0]) : '0;

    mul4x4_core u_core (
        .a_i (core_a),
        .b_i (core_b),
        .p_o (core_p)
    );

    always_comb begin
        acc_d = acc_q;
        a_d   = a_q;
        b_d   = b_q;
        case (state_q)
            IDLE: if (accept) begin
                acc_d = '0;
                a_d   = in_a;
                b_d   = in_b;
            end
            S0, S1, S2, S3:
                acc_d = acc_q + (RESULT_W'(core_p) << STEP_SHIFT[step_idx(state_q)]);
            default: ;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == IDLE);
        busy      = (state_q != IDLE);
        out_valid = (state_q == DONE);
        out_p     = (state_q == DONE) ? acc_q : '0;
    end

endmodule
